// File: rtl/y86_multicycle_seq.sv
// Multi-cycle Y86 sequencer: owns PC, steps FETCH..PCUPDATE, tracks status and counters.
// Latency: 6 cycles per instruction, plus k extra MEMORY cycles while data memory is not ready.
// Backpressure: mem_req is held until mem_ready; MEM_TIMEOUT unanswered cycles raise an ADR fault.
module y86_multicycle_seq #(
    parameter int                  DATA_WID    = 32,
    parameter logic [DATA_WID-1:0] RESET_PC    = '0,
    parameter int                  CNT_WID     = 32,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic                Cnd,
    input  logic [DATA_WID-1:0] valC,
    input  logic [DATA_WID-1:0] valP,
    input  logic [DATA_WID-1:0] valM,
    input  logic                instr_valid,
    input  logic                imem_error,
    input  logic                mem_ready,
    input  logic                dmem_error,
    output logic [DATA_WID-1:0] PC,
    output logic                fetch_en,
    output logic                decode_en,
    output logic                exec_en,
    output logic                wb_en,
    output logic                mem_req,
    output logic                mem_write,
    output logic [2:0]          stat,
    output logic [CNT_WID-1:0]  cycle_cnt,
    output logic [CNT_WID-1:0]  retire_cnt
);

    // Status encodings seen by software.
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // The wait counter only needs to reach MEM_TIMEOUT-1: the cycle on which
    // it holds that value is the last one the request may still be answered.
    localparam int                WAIT_WID  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_WID-1:0] WAIT_LAST = WAIT_WID'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PCUPDATE  = 3'd5,
        S_STOP_HLT  = 3'd6,
        S_STOP_ERR  = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WID-1:0]   pc_q, pc_d;
    logic [2:0]            stat_q, stat_d;
    logic [3:0]            icode_q, icode_d;
    logic [WAIT_WID-1:0]   wait_q, wait_d;
    logic [CNT_WID-1:0]    cycle_q, cycle_d;
    logic [CNT_WID-1:0]    retire_q, retire_d;
    logic                  stopped;
    logic                  run;

    // ifun only fans out to the ALU/regfile blocks; the sequencer never looks at it.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Instructions that talk to data memory: rmmovl, mrmovl, call, ret, pushl, popl.
    function automatic logic is_mem_class(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_class = 1'b1;
            default:                            is_mem_class = 1'b0;
        endcase
    endfunction

    // Of those, rmmovl, call and pushl store to memory.
    function automatic logic is_mem_write(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h8, 4'hA: is_mem_write = 1'b1;
            default:          is_mem_write = 1'b0;
        endcase
    endfunction

    assign stopped = (state_q == S_STOP_HLT) || (state_q == S_STOP_ERR);
    // Reset forces state to FETCH, but no block may be enabled while reset is held.
    assign run     = !RST;

    // Next-state, architectural updates and stage-enable decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        icode_d   = icode_q;
        wait_d    = wait_q;
        retire_d  = retire_q;
        cycle_d   = stopped ? cycle_q : cycle_q + CNT_WID'(1);

        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        wb_en     = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                fetch_en = run;
                icode_d  = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_STOP_ERR;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_STOP_ERR;
                end else if (icode == 4'h0) begin
                    stat_d  = STAT_HLT;
                    state_d = S_STOP_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = run;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                exec_en = run;
                wait_d  = '0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                mem_req   = run && is_mem_class(icode_q);
                mem_write = run && is_mem_class(icode_q) && is_mem_write(icode_q);
                if (!is_mem_class(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    // A late answer on the final allowed cycle still counts as ready.
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_STOP_ERR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    stat_d  = STAT_ADR;
                    state_d = S_STOP_ERR;
                end else begin
                    wait_d = wait_q + WAIT_WID'(1);
                end
            end
            S_WRITEBACK: begin
                wb_en   = run;
                state_d = S_PCUPDATE;
            end
            S_PCUPDATE: begin
                // valM for ret is taken here; data memory keeps it stable since mem_ready.
                if (icode_q == 4'h8 || (icode_q == 4'h7 && Cnd)) begin
                    pc_d = valC;
                end else if (icode_q == 4'h9) begin
                    pc_d = valM;
                end else begin
                    pc_d = valP;
                end
                retire_d = retire_q + CNT_WID'(1);
                state_d  = S_FETCH;
            end
            S_STOP_HLT, S_STOP_ERR: begin
                state_d = state_q;
            end
            default: begin
                stat_d  = STAT_INS;
                state_d = S_STOP_ERR;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Architectural registers: PC, status, latched icode, wait timer, counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            stat_q   <= STAT_AOK;
            icode_q  <= '0;
            wait_q   <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            pc_q     <= pc_d;
            stat_q   <= stat_d;
            icode_q  <= icode_d;
            wait_q   <= wait_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

    assign PC         = pc_q;
    assign stat       = stat_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule
